tmr_redundancy_scheduler: RTL and testbench
===========================================

// Module: tmr_redundancy_scheduler
// PURPOSE
//  Sequences the three redundant command-processing modules and their voter.
//  Chooses simplex/TMR/DMR operation from mode and err_rate, counts per-module vote
//  disagreements, requests scrubs of faulty modules and retires modules that fail
//  twice. Sits between the mode/err_rate inputs and the voter/replica enables.
// PARAMETERS
//  ERR_HI          8   err_rate >= ERR_HI enters TMR (auto mode)
//  ERR_LO          3   err_rate <= ERR_LO counts toward leaving TMR (hysteresis)
//  HOLD_CYC        16  consecutive low-error cycles needed to leave TMR
//  max_fault_count 5   mismatches that declare a module faulty
//  SCRUB_CYC       8   cycles allowed for scrub_ack before the module is retired
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  synchronous reset, active-low
//  mode        in   2  0 auto, 1 hybrid, 2 manual, 3 sleep
//  err_rate    in   4  received-data error rate
//  vote_valid  in   1  voter result valid this cycle
//  mismatch    in   3  bit i: module i disagreed with the majority
//  scrub_ack   in   1  scrub of scrub_id completed
//  mod_en      out  3  replica enables
//  vote_en     out  1  voter active (TMR/DMR)
//  sel_mod     out  2  replica driving the output when vote_en=0
//  fault       out  3  bit i: module i faulty or retired
//  scrub_req   out  1  scrub request, held until ack or timeout
//  scrub_id    out  2  module being scrubbed
//  state_o     out  3  FSM state probe
// BEHAVIOUR
//  Reset (rst=0 at edge): state SLEEP; all outputs 0; counters, retire flags and
//   scrub-used flags cleared. Reset mid-scrub aborts it, scrub_req=0 next cycle.
//  All outputs decoded from registered state only: no input-to-output path; one-cycle latency.
//  States (state_o): SLEEP=0 SIMPLEX=1 TMR=2 DMR=3 SCRUB=4 FAILSAFE=5.
//  SLEEP: mod_en=000. Leaves on mode!=3 -> SIMPLEX (auto/manual) or TMR (hybrid).
//  mode=3 forces SLEEP from any state next cycle; counters/retire flags kept.
//  SIMPLEX: mod_en = onehot(sel_mod), sel_mod = lowest non-retired module, vote_en=0.
//   auto: err_rate>=ERR_HI -> TMR. hybrid -> TMR. manual: stays.
//  TMR: mod_en=111, vote_en=1. auto: low-cycle counter++ while err_rate<=ERR_LO, else
//   cleared; reaching HOLD_CYC -> SIMPLEX. mode=2 -> SIMPLEX.
//  Fault counting (TMR only): vote_valid with exactly one mismatch bit i -> cnt[i]++,
//   saturating at max_fault_count. Two or three bits set: no majority, no counts updated.
//  cnt[i]==max_fault_count: first time -> fault[i]=1, SCRUB, scrub_id=i;
//   module already scrubbed -> retire i, go DMR. Lowest index wins if several qualify.
//  SCRUB: scrub_req=1, mod_en excludes scrub_id, vote_en=0, sel_mod = lowest other module.
//   scrub_ack sampled high -> cnt/fault cleared, scrub-used set, return to TMR (auto/hybrid)
//   or SIMPLEX (manual). No ack within SCRUB_CYC cycles -> retire, DMR.
//   Mode changes other than sleep are deferred until SCRUB exits.
//  DMR: two survivors enabled, vote_en=1; any mismatch bit on a survivor with vote_valid
//   increments a shared counter; at max_fault_count -> FAILSAFE. Sticky vs err_rate.
//  FAILSAFE: mod_en = onehot(lowest survivor), vote_en=0, fault shows retired modules.
//   Exits only via reset or sleep (returns to FAILSAFE on wake).
//  fault[i]=1 whenever module i is retired or being scrubbed.
// TESTING
//  Reset: rst=0 two cycles, mode=0 -> all outputs 0, state_o=0; release -> state_o=1, mod_en=001.
//  Auto hysteresis: err_rate=10 -> state_o=2 next cycle; err_rate=2 for 16 cycles -> state_o=1
//   on cycle 17; a single err_rate=5 at cycle 10 restarts the count.
//  Scrub: hybrid, mismatch=010 valid x5 -> fault=010, scrub_req=1, scrub_id=1; ack -> fault=000, TMR.
//  Retire: repeat on module 1 after scrub -> state_o=3, mod_en=101, fault=010, no scrub_req.
//  Timeout: fault module 0, hold scrub_ack=0 8 cycles -> state_o=3, mod_en=110, fault=001.
//  Ambiguous votes: mismatch=011 valid x20 -> counters unchanged, state stays TMR; mode=3 mid-scrub
//   -> state_o=0, scrub_req=0 next cycle.

Source files
------------

// File: rtl/tmr_redundancy_scheduler.sv
// Sequences three redundant replicas and their voter: simplex/TMR/DMR selection, fault counting, scrub and retire.
// Latency: all outputs decode registered state only; an input takes effect on the outputs one clock later.
// Backpressure: none; scrub_req is held until scrub_ack or the scrub timeout, and inputs are sampled every cycle.
// Ports: clk/rst (sync, active-low); mode, err_rate, vote_valid, mismatch, scrub_ack in;
//        mod_en, vote_en, sel_mod, fault, scrub_req, scrub_id, state_o out.
module tmr_redundancy_scheduler #(
    parameter int ERR_HI          = 8,
    parameter int ERR_LO          = 3,
    parameter int HOLD_CYC        = 16,
    parameter int max_fault_count = 5,
    parameter int SCRUB_CYC       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [3:0] err_rate,
    input  logic       vote_valid,
    input  logic [2:0] mismatch,
    input  logic       scrub_ack,
    output logic [2:0] mod_en,
    output logic       vote_en,
    output logic [1:0] sel_mod,
    output logic [2:0] fault,
    output logic       scrub_req,
    output logic [1:0] scrub_id,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_SLEEP    = 3'd0,
        S_SIMPLEX  = 3'd1,
        S_TMR      = 3'd2,
        S_DMR      = 3'd3,
        S_SCRUB    = 3'd4,
        S_FAILSAFE = 3'd5
    } state_t;

    localparam int CW = $clog2(max_fault_count + 1);
    localparam int LW = $clog2(HOLD_CYC + 1);
    localparam int TW = $clog2(SCRUB_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(max_fault_count);
    localparam logic [LW-1:0] HOLD_LAST = LW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(SCRUB_CYC - 1);
    localparam logic [3:0]    ERR_HI_V  = 4'(ERR_HI);
    localparam logic [3:0]    ERR_LO_V  = 4'(ERR_LO);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt [3];
    logic [CW-1:0]   dmr_cnt;
    logic [LW-1:0]   low_cnt;
    logic [TW-1:0]   timer;
    logic [2:0]      retired;
    logic [2:0]      scrub_used;
    logic [1:0]      sid;
    logic            failsafe_seen;

    function automatic logic [1:0] lowest(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    logic [2:0] hit;
    logic [1:0] hit_idx;
    logic       vote_one;
    logic       low_ok;
    logic [1:0] surv_lo;
    logic [2:0] scrub_pool;
    state_t     red_tgt;

    // Only a single dissenting replica identifies a culprit; 2-3 dissenters mean no majority.
    assign vote_one   = vote_valid && $onehot(mismatch);
    assign low_ok     = err_rate <= ERR_LO_V;
    assign hit        = {cnt[2] == CNT_MAX, cnt[1] == CNT_MAX, cnt[0] == CNT_MAX};
    assign hit_idx    = lowest(hit);
    assign surv_lo    = lowest(~retired);
    assign scrub_pool = ~retired & ~onehot(sid);
    // With a retired replica full TMR is impossible, so redundancy requests land in DMR.
    assign red_tgt    = (|retired) ? S_DMR : S_TMR;

    // State register and bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_SLEEP;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
            dmr_cnt       <= '0;
            low_cnt       <= '0;
            timer         <= '0;
            retired       <= '0;
            scrub_used    <= '0;
            sid           <= '0;
            failsafe_seen <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == S_TMR && vote_one) begin
                for (int i = 0; i < 3; i++)
                    if (mismatch[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
            end

            if (state == S_TMR && mode == 2'd0 && low_ok) low_cnt <= low_cnt + 1'b1;
            else                                          low_cnt <= '0;

            timer <= (state == S_SCRUB) ? timer + 1'b1 : '0;

            if (state == S_TMR && state_nxt == S_SCRUB) sid <= hit_idx;
            if (state == S_TMR && state_nxt == S_DMR)   retired[hit_idx] <= 1'b1;

            if (state == S_SCRUB && state_nxt != S_SLEEP && state_nxt != S_SCRUB) begin
                if (scrub_ack) begin
                    cnt[sid]        <= '0;
                    scrub_used[sid] <= 1'b1;
                end else begin
                    retired[sid]    <= 1'b1;
                end
            end

            if (state == S_DMR && vote_valid && |(mismatch & ~retired) && dmr_cnt != CNT_MAX)
                dmr_cnt <= dmr_cnt + 1'b1;

            if (state_nxt == S_FAILSAFE) failsafe_seen <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (mode == 2'd3) begin
            state_nxt = S_SLEEP;
        end else begin
            case (state)
                S_SLEEP: begin
                    if (failsafe_seen)      state_nxt = S_FAILSAFE;
                    else if (mode == 2'd1)  state_nxt = red_tgt;
                    else                    state_nxt = S_SIMPLEX;
                end
                S_SIMPLEX: begin
                    if (mode == 2'd1 || (mode == 2'd0 && err_rate >= ERR_HI_V))
                        state_nxt = red_tgt;
                end
                S_TMR: begin
                    if (|hit)
                        state_nxt = scrub_used[hit_idx] ? S_DMR : S_SCRUB;
                    else if (mode == 2'd2)
                        state_nxt = S_SIMPLEX;
                    else if (mode == 2'd0 && low_ok && low_cnt == HOLD_LAST)
                        state_nxt = S_SIMPLEX;
                end
                S_SCRUB: begin
                    if (scrub_ack)              state_nxt = (mode == 2'd2) ? S_SIMPLEX : S_TMR;
                    else if (timer == TMO_LAST) state_nxt = S_DMR;
                end
                S_DMR: begin
                    if (dmr_cnt == CNT_MAX) state_nxt = S_FAILSAFE;
                end
                S_FAILSAFE: state_nxt = S_FAILSAFE;
                default:    state_nxt = S_SLEEP;
            endcase
        end
    end

    // Output decode
    always_comb begin
        mod_en    = 3'b000;
        vote_en   = 1'b0;
        sel_mod   = 2'd0;
        scrub_req = 1'b0;
        scrub_id  = 2'd0;
        fault     = retired;
        state_o   = state;
        case (state)
            S_SIMPLEX, S_FAILSAFE: begin
                sel_mod = surv_lo;
                mod_en  = onehot(surv_lo);
            end
            S_TMR: begin
                mod_en  = 3'b111;
                vote_en = 1'b1;
            end
            S_DMR: begin
                mod_en  = ~retired;
                vote_en = 1'b1;
            end
            S_SCRUB: begin
                mod_en    = scrub_pool;
                sel_mod   = lowest(scrub_pool);
                scrub_req = 1'b1;
                scrub_id  = sid;
                fault     = retired | onehot(sid);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tmr_redundancy_scheduler.sv
// Self-checking bench for tmr_redundancy_scheduler: reset, hysteresis, scrub, retire, timeout, ambiguous votes.
// Latency: expectations are queued with each stimulus and compared 1 ns after the clock edge that should produce them.
// Backpressure: not applicable; the bench drives every input each cycle.
module tb_tmr_redundancy_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] err_rate = 4'd0;
    logic       vote_valid = 1'b0;
    logic [2:0] mismatch = 3'b000;
    logic       scrub_ack = 1'b0;
    logic [2:0] mod_en;
    logic       vote_en;
    logic [1:0] sel_mod;
    logic [2:0] fault;
    logic       scrub_req;
    logic [1:0] scrub_id;
    logic [2:0] state_o;

    tmr_redundancy_scheduler dut (
        .clk(clk), .rst(rst), .mode(mode), .err_rate(err_rate),
        .vote_valid(vote_valid), .mismatch(mismatch), .scrub_ack(scrub_ack),
        .mod_en(mod_en), .vote_en(vote_en), .sel_mod(sel_mod), .fault(fault),
        .scrub_req(scrub_req), .scrub_id(scrub_id), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // {state, mod_en, vote_en, sel_mod, fault, scrub_req, scrub_id}
    typedef logic [14:0] obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic obs_t observed();
        return {state_o, mod_en, vote_en, sel_mod, fault, scrub_req, scrub_id};
    endfunction

    function automatic obs_t mk(input logic [2:0] st, input logic [2:0] me, input logic ve,
                                input logic [1:0] sm, input logic [2:0] f, input logic rq,
                                input logic [1:0] id);
        return {st, me, ve, sm, f, rq, id};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // n valid votes with the given pattern, then one idle cycle for the fault decision to register.
    task automatic vote(input logic [2:0] m, input int n);
        vote_valid = 1'b1;
        mismatch   = m;
        step(n);
        vote_valid = 1'b0;
        mismatch   = 3'b000;
        step(1);
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst = 1'b0; mode = 2'd0;
        exp_q.push_back(mk(3'd0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0));
        step(2);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL reset_hold: got %h want %h", o, e); end
        rst = 1'b1;
        exp_q.push_back(mk(3'd1, 3'b001, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0));
        step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL reset_release: got %h want %h", o, e); end
    endtask

    task automatic test_hysteresis();
        obs_t e, o, tmr, smp;
        tmr = mk(3'd2, 3'b111, 1'b1, 2'd0, 3'b000, 1'b0, 2'd0);
        smp = mk(3'd1, 3'b001, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0);
        err_rate = 4'd10; exp_q.push_back(tmr); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL enter_tmr: got %h want %h", o, e); end
        err_rate = 4'd2; exp_q.push_back(tmr); step(15);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL hold_15_low: got %h want %h", o, e); end
        exp_q.push_back(smp); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL leave_after_16_low: got %h want %h", o, e); end
        err_rate = 4'd10; step(1);
        err_rate = 4'd2; step(9);
        err_rate = 4'd5; step(1);
        err_rate = 4'd2; exp_q.push_back(tmr); step(15);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL restart_hold: got %h want %h", o, e); end
        exp_q.push_back(smp); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL restart_leave: got %h want %h", o, e); end
    endtask

    task automatic test_scrub();
        obs_t e, o;
        mode = 2'd1;
        exp_q.push_back(mk(3'd2, 3'b111, 1'b1, 2'd0, 3'b000, 1'b0, 2'd0)); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL hybrid_tmr: got %h want %h", o, e); end
        exp_q.push_back(mk(3'd4, 3'b101, 1'b0, 2'd0, 3'b010, 1'b1, 2'd1));
        vote(3'b010, 5);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL scrub_enter_m1: got %h want %h", o, e); end
        scrub_ack = 1'b1;
        exp_q.push_back(mk(3'd2, 3'b111, 1'b1, 2'd0, 3'b000, 1'b0, 2'd0)); step(1);
        scrub_ack = 1'b0;
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL scrub_ack_return: got %h want %h", o, e); end
    endtask

    task automatic test_retire();
        obs_t e, o;
        exp_q.push_back(mk(3'd3, 3'b101, 1'b1, 2'd0, 3'b010, 1'b0, 2'd0));
        vote(3'b010, 5);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL retire_dmr: got %h want %h", o, e); end
        exp_q.push_back(mk(3'd5, 3'b001, 1'b0, 2'd0, 3'b010, 1'b0, 2'd0));
        vote(3'b001, 5);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL dmr_failsafe: got %h want %h", o, e); end
        mode = 2'd3;
        exp_q.push_back(mk(3'd0, 3'b000, 1'b0, 2'd0, 3'b010, 1'b0, 2'd0)); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL sleep_keeps_retired: got %h want %h", o, e); end
        mode = 2'd1;
        exp_q.push_back(mk(3'd5, 3'b001, 1'b0, 2'd0, 3'b010, 1'b0, 2'd0)); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL wake_failsafe: got %h want %h", o, e); end
    endtask

    task automatic test_timeout();
        obs_t e, o, scr;
        rst = 1'b0; step(1);
        rst = 1'b1; mode = 2'd1;
        exp_q.push_back(mk(3'd2, 3'b111, 1'b1, 2'd0, 3'b000, 1'b0, 2'd0)); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL timeout_tmr: got %h want %h", o, e); end
        scr = mk(3'd4, 3'b110, 1'b0, 2'd1, 3'b001, 1'b1, 2'd0);
        exp_q.push_back(scr);
        vote(3'b001, 5);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL scrub_enter_m0: got %h want %h", o, e); end
        exp_q.push_back(scr); step(7);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL scrub_wait_7: got %h want %h", o, e); end
        exp_q.push_back(mk(3'd3, 3'b110, 1'b1, 2'd0, 3'b001, 1'b0, 2'd0)); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL scrub_timeout: got %h want %h", o, e); end
    endtask

    task automatic test_ambiguous();
        obs_t e, o, tmr, scr;
        tmr = mk(3'd2, 3'b111, 1'b1, 2'd0, 3'b000, 1'b0, 2'd0);
        scr = mk(3'd4, 3'b101, 1'b0, 2'd0, 3'b010, 1'b1, 2'd1);
        rst = 1'b0; step(1);
        rst = 1'b1; mode = 2'd1; step(1);
        exp_q.push_back(tmr);
        vote(3'b011, 20);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL ambiguous_20: got %h want %h", o, e); end
        exp_q.push_back(tmr);
        vote(3'b010, 4);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL counts_from_zero: got %h want %h", o, e); end
        exp_q.push_back(scr);
        vote(3'b010, 1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL fifth_vote_scrub: got %h want %h", o, e); end
        mode = 2'd2;
        exp_q.push_back(scr); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL scrub_defers_mode: got %h want %h", o, e); end
        mode = 2'd3;
        exp_q.push_back(mk(3'd0, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 2'd0)); step(1);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL sleep_aborts_scrub: got %h want %h", o, e); end
    endtask

    initial begin
        #1;
        test_reset();
        test_hysteresis();
        test_scrub();
        test_retire();
        test_timeout();
        test_ambiguous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
